// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the unified single-port CPU memory.
// Port 0 is the CPU datapath, port 1 the debug/loader port. Each access
// walks IDLE -> ACCESS -> DONE: grant and latch in IDLE, drive the memory
// for exactly one cycle in ACCESS, pulse the owner's ack in DONE.
// CPU stores into the instruction region are suppressed and flagged on err0.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int INST_WORDS = 32
) (
   input  logic              clk,
   input  logic              reset,
   // port 0: CPU datapath
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   output logic [DATA_W-1:0] rdata0,
   output logic              err0,
   // port 1: debug/loader
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              lock1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata1,
   // memory side
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Word-index limit of the protected instruction region, sized to the
   // word-address field it is compared against.
   localparam logic [ADDR_W-3:0] INST_LIMIT = (ADDR_W-2)'(INST_WORDS);

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic              err0_q, err0_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic              grant_valid;
   logic              grant_port;
   logic              prot;

   // A CPU-owned access that targets the instruction region.
   assign prot = ~owner_q & (addr_q[ADDR_W-1:2] < INST_LIMIT);

   // Arbitration, latching and completion: next-state for every flop.
   always_comb begin
      // NOTE: every _d starts from its _q (or a pulse default) so no path
      // leaves a variable unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      err0_d       = 1'b0;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      grant_valid  = 1'b0;
      grant_port   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req1 && lock1 && last_grant_q) begin
               // Port 1 holds the bus while it keeps lock1 asserted.
               grant_valid = 1'b1;
               grant_port  = 1'b1;
            end else if (req0 && req1) begin
               grant_valid = 1'b1;
               grant_port  = ~last_grant_q;
            end else if (req0) begin
               grant_valid = 1'b1;
               grant_port  = 1'b0;
            end else if (req1) begin
               grant_valid = 1'b1;
               grant_port  = 1'b1;
            end

            if (grant_valid) begin
               owner_d      = grant_port;
               last_grant_d = grant_port;
               we_d         = grant_port ? we1    : we0;
               addr_d       = grant_port ? addr1  : addr0;
               wdata_d      = grant_port ? wdata1 : wdata0;
               state_d      = ACCESS;
            end
         end

         ACCESS: begin
            if (!we_q) begin
               if (owner_q) rdata1_d = mem_rdata;
               else         rdata0_d = mem_rdata;
            end
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
            err0_d  = prot & we_q;
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with asynchronous reset; last_grant resets to 1 so
   // port 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         err0_q       <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge
         // values regardless of statement order.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         err0_q       <= err0_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // Memory strobes decode from state and latches only; an asynchronous
   // reset drops them immediately because state_q leaves ACCESS at once.
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_read  = (state_q == ACCESS) & ~we_q;
   assign mem_write = (state_q == ACCESS) & we_q & ~prot;

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign err0   = err0_q;
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Expected completions are queued
// when stimulus is driven; a monitor pops and compares on every ack.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              req0, we0, req1, we1, lock1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              ack0, ack1, err0;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_read, mem_write;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_WORDS(32)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .ack0(ack0), .rdata0(rdata0), .err0(err0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
      .ack1(ack1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
   );

   // Memory model: 64 words, combinational read, write on the clock edge.
   logic [31:0] mem [0:63] = '{0: 32'h20042f5b, 4: 32'h10070001,
                               33: 32'hA5A50084, default: 32'h0};
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          port;
      logic [31:0] rdata;
      bit          err;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   logic [31:0] last_rd [2];   // value each port's rdata should hold after its next ack
   logic [31:0] rd_model [2];  // value each port's rdata currently holds
   int          checks = 0;
   int          errors = 0;

   function automatic void push_exp(bit port, bit is_read, logic [31:0] rd, bit err);
      exp_t e;
      if (is_read) last_rd[port] = rd;
      e.port  = port;
      e.rdata = last_rd[port];
      e.err   = err;
      exp_q.push_back(e);
   endfunction

   // Monitor: every ack is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (ack0 || ack1) begin
         checks++;
         if (ack0 && ack1) begin
            errors++;
            $display("FAIL both_acks ack0=%0b ack1=%0b expected one", ack0, ack1);
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ack ack0=%0b ack1=%0b expected none (t=%0t)", ack0, ack1, $time);
         end else begin
            mon_e = exp_q.pop_front();
            if (ack1 !== mon_e.port) begin
               errors++;
               $display("FAIL ack_port got=%0d expected=%0d", ack1, mon_e.port);
            end
            checks++;
            if ((mon_e.port ? rdata1 : rdata0) !== mon_e.rdata) begin
               errors++;
               $display("FAIL rdata port%0d got=%h expected=%h", mon_e.port,
                        mon_e.port ? rdata1 : rdata0, mon_e.rdata);
            end
            checks++;
            if (err0 !== mon_e.err) begin
               errors++;
               $display("FAIL err0 got=%0b expected=%0b", err0, mon_e.err);
            end
            checks++;
            if ((mon_e.port ? rdata0 : rdata1) !== rd_model[~mon_e.port]) begin
               errors++;
               $display("FAIL nonowner_rdata got=%h expected=%h",
                        mon_e.port ? rdata0 : rdata1, rd_model[~mon_e.port]);
            end
            rd_model[mon_e.port] = mon_e.rdata;
         end
      end
      if (err0 && !ack0) begin
         checks++;
         errors++;
         $display("FAIL err0_without_ack err0=%0b ack0=%0b", err0, ack0);
      end
   end

   task automatic drive_req(input bit port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd);
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
      end
   endtask

   // One access on one port; reports latency and strobe counts.
   task automatic single_access(input bit port, input bit we, input logic [31:0] addr,
                                input logic [31:0] wd, output int lat,
                                output int rd_cnt, output int wr_cnt);
      bit got = 1'b0;
      lat = 0; rd_cnt = 0; wr_cnt = 0;
      @(posedge clk); #1;
      drive_req(port, we, addr, wd);
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (mem_read)  rd_cnt++;
         if (mem_write) wr_cnt++;
         if (port ? ack1 : ack0) got = 1'b1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ack_timeout port%0d got=no_ack expected=ack", port);
      end
      @(posedge clk); #1;
      if (port) req1 = 1'b0; else req0 = 1'b0;
   endtask

   task automatic test_reset();
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
      last_rd[0] = '0; last_rd[1] = '0; rd_model[0] = '0; rd_model[1] = '0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks += 7;
      if (ack0 !== 1'b0)     begin errors++; $display("FAIL rst_ack0 got=%b expected=0", ack0); end
      if (ack1 !== 1'b0)     begin errors++; $display("FAIL rst_ack1 got=%b expected=0", ack1); end
      if (err0 !== 1'b0)     begin errors++; $display("FAIL rst_err0 got=%b expected=0", err0); end
      if (rdata0 !== '0)     begin errors++; $display("FAIL rst_rdata0 got=%h expected=0", rdata0); end
      if (rdata1 !== '0)     begin errors++; $display("FAIL rst_rdata1 got=%h expected=0", rdata1); end
      if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got=%b expected=0", mem_read); end
      if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got=%b expected=0", mem_write); end
      reset = 1'b0;
   endtask

   task automatic test_first_read();
      int lat, rc, wc;
      push_exp(0, 1, 32'h20042f5b, 0);
      single_access(0, 0, 32'h0, 32'h0, lat, rc, wc);
      checks += 3;
      if (lat !== 3) begin errors++; $display("FAIL first_latency got=%0d expected=3", lat); end
      if (rc !== 1)  begin errors++; $display("FAIL first_mem_read_cycles got=%0d expected=1", rc); end
      if (wc !== 0)  begin errors++; $display("FAIL first_mem_write_cycles got=%0d expected=0", wc); end
   endtask

   task automatic test_port1_write_read();
      int lat, rc, wc;
      push_exp(1, 0, 32'h0, 0);
      single_access(1, 1, 32'h80, 32'hDEADBEEF, lat, rc, wc);
      checks += 2;
      if (wc !== 1) begin errors++; $display("FAIL p1_write_cycles got=%0d expected=1", wc); end
      if (rc !== 0) begin errors++; $display("FAIL p1_write_read_cycles got=%0d expected=0", rc); end
      push_exp(1, 1, 32'hDEADBEEF, 0);
      single_access(1, 0, 32'h80, 32'h0, lat, rc, wc);
      checks++;
      if (rc !== 1) begin errors++; $display("FAIL p1_read_cycles got=%0d expected=1", rc); end
   endtask

   task automatic test_fairness();
      int t [4];
      int n = 0;
      for (int k = 0; k < 4; k++) push_exp(k[0], 1, 32'hA5A50084, 0);
      @(posedge clk); #1;
      lock1 = 1'b0;
      drive_req(0, 0, 32'h84, 32'h0);
      drive_req(1, 0, 32'h84, 32'h0);
      for (int i = 0; i < 40 && n < 4; i++) begin
         @(negedge clk);
         if (ack0 || ack1) begin t[n] = cyc; n++; end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (n !== 4) begin errors++; $display("FAIL fair_ack_count got=%0d expected=4", n); end
      for (int k = 1; k < n; k++) begin
         checks++;
         if (t[k] - t[k-1] !== 3) begin
            errors++;
            $display("FAIL fair_spacing got=%0d expected=3", t[k] - t[k-1]);
         end
      end
   endtask

   task automatic test_protect();
      int lat, rc, wc;
      push_exp(0, 0, 32'h0, 1);
      single_access(0, 1, 32'h10, 32'h12345678, lat, rc, wc);
      checks++;
      if (wc !== 0) begin errors++; $display("FAIL prot_mem_write got=%0d expected=0", wc); end
      push_exp(0, 1, 32'h10070001, 0);
      single_access(0, 0, 32'h10, 32'h0, lat, rc, wc);
      // port 1 may write inside the instruction region
      push_exp(1, 0, 32'h0, 0);
      single_access(1, 1, 32'h08, 32'hCAFE0008, lat, rc, wc);
      checks += 2;
      if (wc !== 1) begin errors++; $display("FAIL p1_inst_write_cycles got=%0d expected=1", wc); end
      if (mem[2] !== 32'hCAFE0008) begin
         errors++; $display("FAIL p1_inst_write_data got=%h expected=cafe0008", mem[2]);
      end
   endtask

   task automatic test_lock();
      int n = 0;
      for (int k = 0; k < 4; k++) push_exp(1, 1, 32'hA5A50084, 0);
      push_exp(0, 1, 32'hA5A50084, 0);
      @(posedge clk); #1;
      lock1 = 1'b1;
      drive_req(0, 0, 32'h84, 32'h0);
      drive_req(1, 0, 32'h84, 32'h0);
      for (int i = 0; i < 60 && n < 5; i++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            n++;
            if (n == 4) begin @(posedge clk); #1; lock1 = 1'b0; end
         end
      end
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (n !== 5) begin errors++; $display("FAIL lock_ack_count got=%0d expected=5", n); end
   endtask

   task automatic test_reset_mid_access();
      bit got = 1'b0;
      int n = 0;
      @(posedge clk); #1;
      drive_req(1, 0, 32'h80, 32'h0);
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (mem_read) got = 1'b1;
      end
      checks++;
      if (!got) begin errors++; $display("FAIL midrst_access_timeout got=no_read expected=read"); end
      drive_req(0, 0, 32'h0, 32'h0);
      #1 reset = 1'b1;
      #1;
      checks++;
      if (mem_read !== 1'b0) begin errors++; $display("FAIL midrst_mem_read got=%b expected=0", mem_read); end
      repeat (2) @(negedge clk);
      checks += 3;
      if (ack1 !== 1'b0)  begin errors++; $display("FAIL midrst_ack1 got=%b expected=0", ack1); end
      if (rdata0 !== '0)  begin errors++; $display("FAIL midrst_rdata0 got=%h expected=0", rdata0); end
      if (rdata1 !== '0)  begin errors++; $display("FAIL midrst_rdata1 got=%h expected=0", rdata1); end
      last_rd[0] = '0; last_rd[1] = '0; rd_model[0] = '0; rd_model[1] = '0;
      push_exp(0, 1, 32'h20042f5b, 0);
      push_exp(1, 1, 32'hDEADBEEF, 0);
      reset = 1'b0;
      for (int i = 0; i < 30 && n < 2; i++) begin
         @(negedge clk);
         if (ack0) begin n++; @(posedge clk); #1; req0 = 1'b0; end
         else if (ack1) begin n++; @(posedge clk); #1; req1 = 1'b0; end
      end
      req0 = 1'b0; req1 = 1'b0;
      checks++;
      if (n !== 2) begin errors++; $display("FAIL midrst_ack_count got=%0d expected=2", n); end
   endtask

   initial begin
      test_reset();
      test_first_read();
      test_port1_write_read();
      test_fairness();
      test_protect();
      test_lock();
      test_reset_mid_access();
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL pending_expectations got=%0d expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout expected=completion");
      $fatal(1, "simulation did not complete");
   end

endmodule
